// File: rtl/or_and_demux.sv
// Registered bitwise AND/OR stage whose gate functions are built only
// from 1:2 demultiplexer primitives. Results appear one clock after a
// valid operand pair, qualified by out_valid.

// 1:2 demultiplexer: routes din to y0 when sel=0, to y1 when sel=1;
// the unselected output is forced low.
module or_and_demux_dmx (
  input  logic sel,
  input  logic din,
  output logic y0,
  output logic y1
);

  assign y0 = sel ? 1'b0 : din;
  assign y1 = sel ? din  : 1'b0;

endmodule

module or_and_demux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_and_b,
  output logic [WIDTH-1:0] a_or_b,
  output logic             out_valid
);

  // Stage p0: combinational gate functions, one demux pair per bit
  logic [WIDTH-1:0] and_p0;
  logic [WIDTH-1:0] nor_p0;
  logic [WIDTH-1:0] or_p0;
  logic [WIDTH-1:0] and_y0_unused;
  logic [WIDTH-1:0] or_y1_unused;
  logic [WIDTH-1:0] b_inv;

  assign b_inv = ~b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // AND: b[i] passes to y1 only when a[i]=1.
    or_and_demux_dmx u_and (
      .sel (a[i]),
      .din (b[i]),
      .y0  (and_y0_unused[i]),
      .y1  (and_p0[i])
    );

    // NOR: ~b[i] passes to y0 only when a[i]=0, giving ~a & ~b;
    // inverting that yields a | b.
    or_and_demux_dmx u_or (
      .sel (a[i]),
      .din (b_inv[i]),
      .y0  (nor_p0[i]),
      .y1  (or_y1_unused[i])
    );
  end

  assign or_p0 = ~nor_p0;

  // Stage p1: output registers
  logic [WIDTH-1:0] and_p1;
  logic [WIDTH-1:0] or_p1;
  logic             vld_p1;

  // Capture results on a valid input, hold otherwise; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      and_p1 <= '0;
      or_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        and_p1 <= and_p0;
        or_p1  <= or_p0;
      end
    end
  end

  assign a_and_b   = and_p1;
  assign a_or_b    = or_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_or_and_demux.sv
// Randomised and directed bench for or_and_demux at widths 1, 2 and 4,
// compared against a behavioural model of the registered AND/OR stage.
module tb_or_and_demux;

  localparam int NDUT = 3;
  localparam int WID [NDUT] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Stimulus per instance, stored at full 64-bit width and sliced per port.
  logic        va [NDUT];
  logic [63:0] ia [NDUT];
  logic [63:0] ib [NDUT];

  // Observed outputs, zero-extended to 64 bits.
  logic [63:0] oand [NDUT];
  logic [63:0] oor  [NDUT];
  logic        ovld [NDUT];

  // Reference model state.
  logic [63:0] m_and [NDUT];
  logic [63:0] m_or  [NDUT];
  logic        m_vld [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:0] and1, or1;
  logic [1:0] and2, or2;
  logic [3:0] and4, or4;
  logic       ov1, ov2, ov4;

  always #5 clk = ~clk;

  or_and_demux #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(va[0]), .a(ia[0][0:0]), .b(ib[0][0:0]),
    .a_and_b(and1), .a_or_b(or1), .out_valid(ov1)
  );
  or_and_demux #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(va[1]), .a(ia[1][1:0]), .b(ib[1][1:0]),
    .a_and_b(and2), .a_or_b(or2), .out_valid(ov2)
  );
  or_and_demux #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(va[2]), .a(ia[2][3:0]), .b(ib[2][3:0]),
    .a_and_b(and4), .a_or_b(or4), .out_valid(ov4)
  );

  assign oand[0] = {63'd0, and1};
  assign oand[1] = {62'd0, and2};
  assign oand[2] = {60'd0, and4};
  assign oor[0]  = {63'd0, or1};
  assign oor[1]  = {62'd0, or2};
  assign oor[2]  = {60'd0, or4};
  assign ovld[0] = ov1;
  assign ovld[1] = ov2;
  assign ovld[2] = ov4;

  function automatic logic [63:0] mask(input int k);
    return (64'd1 << WID[k]) - 64'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_and_w%0d", tag, WID[k]), oand[k], m_and[k]);
      check($sformatf("%s_or_w%0d", tag, WID[k]), oor[k], m_or[k]);
      check($sformatf("%s_vld_w%0d", tag, WID[k]), {63'd0, ovld[k]}, {63'd0, m_vld[k]});
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NDUT; k++) begin
      m_and[k] = '0;
      m_or[k]  = '0;
      m_vld[k] = 1'b0;
    end
  endtask

  // One rising edge: advance the model from the sampled inputs, then check.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        m_vld[k] = va[k];
        if (va[k]) begin
          m_and[k] = ia[k] & ib[k] & mask(k);
          m_or[k]  = (ia[k] | ib[k]) & mask(k);
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input int k, input logic v, input logic [63:0] av, input logic [63:0] bv);
    va[k] = v;
    ia[k] = av & mask(k);
    ib[k] = bv & mask(k);
  endtask

  task automatic drive_rand(input int k, input logic v);
    drive(k, v, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Drive the same per-bit pattern (replicated across the word) into every instance.
  task automatic drive_bits(input logic v, input logic abit, input logic bbit);
    for (int k = 0; k < NDUT; k++)
      drive(k, v, abit ? '1 : '0, bbit ? '1 : '0);
  endtask

  logic [1:0] sweep_a [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [1:0] sweep_b [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1};

  initial begin
    model_clear();
    for (int k = 0; k < NDUT; k++) drive(k, 1'b0, '0, '0);

    // Power-on reset.
    cycle("por");
    cycle("por");
    @(negedge clk);
    rst = 1'b0;

    // Load all-ones so the outputs are non-zero before the async reset test.
    drive_bits(1'b1, 1'b1, 1'b1);
    cycle("load11");

    // Asynchronous reset between edges, operands active.
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    cycle("rst_hold");
    cycle("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // Truth-table sweep 00,01,10,11,01 back-to-back.
    for (int i = 0; i < 5; i++) begin
      drive_bits(1'b1, sweep_a[i][0], sweep_b[i][0]);
      cycle("sweep");
    end

    // Hold: invalid cycle with zero operands must not disturb results.
    // The sweep ended on 01; capture 11 first so the hold is of ones.
    drive_bits(1'b1, 1'b1, 1'b1);
    cycle("pre_hold");
    drive_bits(1'b0, 1'b0, 1'b0);
    cycle("hold");
    cycle("hold2");

    // Width-4 directed patterns.
    drive_rand(0, 1'b1);
    drive_rand(1, 1'b1);
    drive(2, 1'b1, 64'hC, 64'hA);
    cycle("w4_c_a");
    check("w4_and_lit", oand[2], 64'h8);
    check("w4_or_lit", oor[2], 64'hE);
    drive(2, 1'b1, 64'hF, 64'h0);
    cycle("w4_f_0");
    check("w4_and_f0", oand[2], 64'h0);
    check("w4_or_f0", oor[2], 64'hF);

    // Mid-stream reset pulse between edges.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NDUT; k++) drive_rand(k, 1'b1);
      cycle("stream");
    end
    for (int k = 0; k < NDUT; k++) drive(k, 1'b1, 64'h1, 64'h0);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all("mid_rst");
    #1;
    rst = 1'b0;
    cycle("post_rst");
    check("post_rst_or_w1", oor[0], 64'h1);
    check("post_rst_and_w1", oand[0], 64'h0);

    // Exhaustive width-2 sweep, back-to-back.
    for (int p = 0; p < 16; p++) begin
      drive(1, 1'b1, 64'(p >> 2), 64'(p & 3));
      drive_rand(0, 1'b1);
      drive_rand(2, 1'b1);
      cycle("exh_w2");
    end

    // Random operands and random valid pattern.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NDUT; k++) drive_rand(k, 1'($urandom_range(0, 1)));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
